// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: state encoding,
// coin values, default price table and the price lookup helper.
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      VEND    = 2'd2,
      CHANGE  = 2'd3
   } state_t;

   localparam logic [1:0] COIN_NONE = 2'd0;
   localparam logic [1:0] COIN_MAX  = 2'd3;

   localparam int          DEF_NUM_ITEMS = 4;
   localparam int          DEF_CREDIT_W  = 4;
   localparam logic [15:0] DEF_PRICES    = {4'd2, 4'd1, 4'd3, 4'd2};

   // Slice (item-1) of a packed price vector; the vector is zero-extended so
   // one helper serves any NUM_ITEMS*CREDIT_W up to 256 bits.
   function automatic logic [31:0] price_lookup(input logic [255:0] prices,
                                                input int unsigned  item,
                                                input int unsigned  credit_w);
      return 32'(prices >> ((item - 1) * credit_w)) & ((32'd1 << credit_w) - 32'd1);
   endfunction

endpackage

// File: rtl/vend_change_unit.sv
// Pays out a loaded credit amount over the hopper ready/valid handshake,
// largest coin first, and flags the beat that empties the balance.
module vend_change_unit
   import vend_pkg::*;
#(
   parameter int CREDIT_W = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_load,
   input  logic [CREDIT_W-1:0] i_amount,
   input  logic                i_ready,
   output logic                o_valid,
   output logic [1:0]          o_coin,
   output logic [CREDIT_W-1:0] o_remain,
   output logic                o_done
);

   logic                r_active;
   logic [CREDIT_W-1:0] r_remain;
   logic [1:0]          w_coin;

   assign w_coin   = (r_remain > CREDIT_W'(COIN_MAX)) ? COIN_MAX : r_remain[1:0];
   assign o_valid  = r_active;
   assign o_coin   = r_active ? w_coin : COIN_NONE;
   assign o_remain = r_remain;
   assign o_done   = r_active && i_ready && (r_remain == CREDIT_W'(w_coin));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_active <= 1'b0;
         r_remain <= '0;
      end else if (i_load) begin
         r_active <= 1'b1;
         r_remain <= i_amount;
      end else if (r_active && i_ready) begin
         r_remain <= r_remain - CREDIT_W'(w_coin);
         if (o_done) r_active <= 1'b0;
      end
   end

endmodule

// File: rtl/vend_ctrl.sv
// Parametrised vending controller: item select, coin collection with
// inactivity timeout and cancel, one-cycle vend pulse, handshaked change.
//
// state   | meaning
// IDLE    | waiting for a valid item choice, coins rejected
// COLLECT | accumulating credit toward the selected price
// VEND    | one-cycle dispense pulse for the selected item
// CHANGE  | paying out remaining credit through the hopper
module vend_ctrl
   import vend_pkg::*;
#(
   parameter int                            NUM_ITEMS = DEF_NUM_ITEMS,
   parameter int                            ITEM_W    = 3,
   parameter int                            CREDIT_W  = DEF_CREDIT_W,
   parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES    = DEF_PRICES,
   parameter int                            TIMEOUT   = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ITEM_W-1:0]   choice,
   input  logic [1:0]          coin,
   input  logic                cancel,
   input  logic                change_ready,
   output logic [ITEM_W-1:0]   item_out,
   output logic                vend_valid,
   output logic [1:0]          change_coin,
   output logic                change_valid,
   output logic                coin_reject,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy
);

   localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_t              r_state;
   logic [ITEM_W-1:0]   r_sel;
   logic [CREDIT_W-1:0] r_price;
   logic [CREDIT_W-1:0] r_credit;
   logic [TMR_W-1:0]    r_timer;
   logic                r_coin_reject;

   logic [CREDIT_W:0]   w_sum;
   logic                w_choice_ok;
   logic                w_refund;
   logic                w_load;
   logic [CREDIT_W-1:0] w_remain;
   logic                w_chg_done;

   assign w_sum       = {1'b0, r_credit} + (CREDIT_W+1)'(coin);
   assign w_choice_ok = (choice != '0) && ({1'b0, choice} <= (ITEM_W+1)'(NUM_ITEMS));
   assign w_refund    = (r_state == COLLECT) &&
                        (cancel || ((coin == COIN_NONE) && (r_timer == TMR_W'(TIMEOUT-1))));
   // The change unit samples r_credit on the same edge that clears it here.
   assign w_load      = (w_refund || (r_state == VEND)) && (r_credit != '0);

   vend_change_unit #(.CREDIT_W(CREDIT_W)) u_change (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_load),
      .i_amount (r_credit),
      .i_ready  (change_ready),
      .o_valid  (change_valid),
      .o_coin   (change_coin),
      .o_remain (w_remain),
      .o_done   (w_chg_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= IDLE;
         r_sel         <= '0;
         r_price       <= '0;
         r_credit      <= '0;
         r_timer       <= '0;
         r_coin_reject <= 1'b0;
      end else begin
         r_coin_reject <= (coin != COIN_NONE) && !((r_state == COLLECT) && !cancel);
         case (r_state)
            IDLE: begin
               if (w_choice_ok) begin
                  r_sel   <= choice;
                  r_price <= CREDIT_W'(price_lookup(256'(PRICES), 32'(choice), CREDIT_W));
                  r_timer <= '0;
                  r_state <= COLLECT;
               end
            end
            COLLECT: begin
               if (w_refund) begin
                  r_state  <= (r_credit != '0) ? CHANGE : IDLE;
                  r_credit <= '0;
               end else if (coin != COIN_NONE) begin
                  r_timer <= '0;
                  if (w_sum >= {1'b0, r_price}) begin
                     r_credit <= CREDIT_W'(w_sum - {1'b0, r_price});
                     r_state  <= VEND;
                  end else begin
                     r_credit <= w_sum[CREDIT_W-1:0];
                  end
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            VEND: begin
               r_state  <= (r_credit != '0) ? CHANGE : IDLE;
               r_credit <= '0;
            end
            CHANGE: begin
               if (w_chg_done) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign vend_valid  = (r_state == VEND);
   assign item_out    = (r_state == VEND) ? r_sel : '0;
   assign busy        = (r_state != IDLE);
   assign credit      = (r_state == CHANGE) ? w_remain : r_credit;
   assign coin_reject = r_coin_reject;

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: directed purchase scenarios then random traffic, all
// checked each cycle against a purchase-level reference model.
module tb_vend_ctrl;

   localparam int TIMEOUT = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] choice;
   logic [1:0] coin;
   logic       cancel;
   logic       change_ready;
   logic [2:0] item_out;
   logic       vend_valid;
   logic [1:0] change_coin;
   logic       change_valid;
   logic       coin_reject;
   logic [3:0] credit;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   // Price of item 1..4 as listed for the default configuration.
   int price [5] = '{0, 2, 3, 1, 2};

   // Model: the purchase being paid for, the item dispensing now, and the
   // change still owed to the customer.
   int m_item;
   int m_paid;
   int m_idle;
   int m_vend;
   int m_owed;
   int m_rej;

   vend_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .choice       (choice),
      .coin         (coin),
      .cancel       (cancel),
      .change_ready (change_ready),
      .item_out     (item_out),
      .vend_valid   (vend_valid),
      .change_coin  (change_coin),
      .change_valid (change_valid),
      .coin_reject  (coin_reject),
      .credit       (credit),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   task automatic check_outputs();
      int e_cv;
      e_cv = (m_vend == 0 && m_owed > 0) ? 1 : 0;
      chk("vend_valid",   32'(vend_valid),   (m_vend != 0) ? 1 : 0);
      chk("item_out",     32'(item_out),     m_vend);
      chk("change_valid", 32'(change_valid), e_cv);
      chk("change_coin",  32'(change_coin),  (e_cv != 0) ? ((m_owed > 3) ? 3 : m_owed) : 0);
      chk("credit",       32'(credit),       (m_item != 0) ? m_paid : m_owed);
      chk("busy",         32'(busy),         (m_item != 0 || m_vend != 0 || m_owed > 0) ? 1 : 0);
      chk("coin_reject",  32'(coin_reject),  m_rej);
   endtask

   task automatic model_step(input int ch, input int cn, input bit ca, input bit rd, input bit rs);
      if (rs) begin
         m_item = 0; m_paid = 0; m_idle = 0; m_vend = 0; m_owed = 0; m_rej = 0;
      end else if (m_vend != 0) begin
         m_vend = 0;
         m_rej  = (cn != 0);
      end else if (m_owed > 0) begin
         m_rej = (cn != 0);
         if (rd) m_owed -= (m_owed > 3) ? 3 : m_owed;
      end else if (m_item != 0) begin
         m_rej = ca && (cn != 0);
         if (ca) begin
            m_owed = m_paid; m_item = 0; m_paid = 0;
         end else if (cn != 0) begin
            m_paid += cn;
            m_idle = 0;
            if (m_paid >= price[m_item]) begin
               m_owed = m_paid - price[m_item];
               m_vend = m_item;
               m_item = 0; m_paid = 0;
            end
         end else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
               m_owed = m_paid; m_item = 0; m_paid = 0;
            end
         end
      end else begin
         m_rej = (cn != 0);
         if (ch >= 1 && ch <= 4) begin
            m_item = ch; m_paid = 0; m_idle = 0;
         end
      end
   endtask

   task automatic cyc(input int ch, input int cn, input bit ca, input bit rd, input bit rs);
      @(negedge clk);
      check_outputs();
      choice = 3'(ch); coin = 2'(cn); cancel = ca; change_ready = rd; reset = rs;
      @(posedge clk);
      model_step(ch, cn, ca, rd, rs);
   endtask

   task automatic idle(input int n, input bit rd);
      for (int i = 0; i < n; i++) cyc(0, 0, 1'b0, rd, 1'b0);
   endtask

   initial begin
      reset = 1'b1; choice = '0; coin = '0; cancel = 1'b0; change_ready = 1'b0;
      m_item = 0; m_paid = 0; m_idle = 0; m_vend = 0; m_owed = 0; m_rej = 0;
      @(posedge clk);
      cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1);
      idle(2, 0);

      // Exact price, no change.
      cyc(1, 0, 0, 1, 0); cyc(0, 1, 0, 1, 0); cyc(0, 1, 0, 1, 0);
      idle(3, 1);

      // Overpay, change with ready held; a coin during VEND is rejected.
      cyc(3, 0, 0, 1, 0); cyc(0, 3, 0, 1, 0); cyc(0, 1, 0, 1, 0);
      idle(3, 1);

      // Change stalled by the hopper, then released.
      cyc(2, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 3, 0, 0, 0);
      idle(6, 0); idle(3, 1);

      // Cancel beats a simultaneous coin; coin during CHANGE rejected.
      cyc(4, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 2, 1, 0, 0);
      cyc(0, 2, 0, 0, 0); cyc(0, 3, 0, 0, 0); idle(3, 1);

      // Inactivity timeout refund, then out-of-range and zero choices.
      cyc(2, 0, 0, 0, 0); cyc(0, 2, 0, 0, 0);
      idle(TIMEOUT + 3, 0); idle(3, 1);
      cyc(7, 0, 0, 1, 0); cyc(0, 0, 0, 1, 0); cyc(5, 0, 0, 1, 0); idle(2, 1);

      // Reset in the middle of a stalled payout, then a clean purchase.
      cyc(3, 0, 0, 0, 0); cyc(0, 3, 0, 0, 0); idle(3, 0);
      cyc(0, 0, 0, 0, 1);
      cyc(1, 0, 0, 1, 0); cyc(0, 2, 0, 1, 0); idle(3, 1);

      for (int i = 0; i < 4000; i++) begin
         int ch, cn;
         bit ca, rd, rs;
         ch = $urandom_range(0, 7);
         if (i < 2000) cn = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
         else          cn = ($urandom_range(0, 23) == 0) ? $urandom_range(1, 3) : 0;
         ca = ($urandom_range(0, 31) == 0);
         rd = ($urandom_range(0, 1) == 0);
         rs = ($urandom_range(0, 299) == 0);
         cyc(ch, cn, ca, rd, rs);
      end

      @(negedge clk);
      check_outputs();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
